// File: rtl/vector_memory_banked.sv
// ---------------------------------------------------------------------------
// vector_memory_banked
//
// Banked vector memory for the SIMD lane datapath. One request carries a base
// address, a signed stride and a lane mask for either a gather-read or a
// scatter-write. Lane addresses are spread over NUM_BANKS interleaved
// single-port banks. Lanes that land in the same bank are served over several
// ISSUE rounds, lowest lane first. One response is returned once every
// active lane has been served.
//
// Optional feature macro: VECTOR_MEMORY_BANKED_CONFLICT_CNT_EN
//   When defined, the conflict_cycles output exists. It is a saturating count
//   of ISSUE cycles beyond the first ISSUE cycle of each transaction.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous reset, active low (asserted when 0)
//   req_valid       request valid
//   req_ready       request ready (high only in IDLE)
//   req_write       1 = scatter-write, 0 = gather-read
//   req_base        address of lane 0
//   req_stride      two's-complement element stride
//   req_mask        active-lane mask
//   req_wdata       write data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid       response valid
//   rsp_ready       response accept
//   rsp_write       echo of req_write for this transaction
//   rsp_rdata       gathered read data (all zero for writes and masked lanes)
//   conflict_cycles extra ISSUE cycle count (optional feature only)
// ---------------------------------------------------------------------------
module vector_memory_banked #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_LANES  = 64,
  parameter int NUM_BANKS  = 64,
  parameter int BANK_DEPTH = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [ADDR_WIDTH-1:0]           req_base,
  input  logic [ADDR_WIDTH-1:0]           req_stride,
  input  logic [NUM_LANES-1:0]            req_mask,
  input  logic [DATA_WIDTH*NUM_LANES-1:0] req_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [DATA_WIDTH*NUM_LANES-1:0] rsp_rdata
`ifdef VECTOR_MEMORY_BANKED_CONFLICT_CNT_EN
  ,
  output logic [31:0]                     conflict_cycles
`endif
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(BANK_DEPTH);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

  state_t                          state_q, state_d;
  logic                            req_ready_q, req_ready_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic                            write_q, write_d;
  logic [NUM_LANES-1:0]            pending_q, pending_d;
  logic [ADDR_WIDTH-1:0]           addr_q [NUM_LANES];
  logic [ADDR_WIDTH-1:0]           addr_d [NUM_LANES];
  logic [DATA_WIDTH*NUM_LANES-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH*NUM_LANES-1:0] rsp_rdata_q, rsp_rdata_d;

  // Read return tracking: which bank produced a read last cycle and for which lane.
  logic [NUM_BANKS-1:0]            rd_vld_q, rd_vld_d;
  logic [LANE_W-1:0]               rd_lane_q [NUM_BANKS];
  logic [LANE_W-1:0]               rd_lane_d [NUM_BANKS];

  // Bank storage and the per-bank registered read port.
  logic [DATA_WIDTH-1:0]           mem [NUM_BANKS][BANK_DEPTH];
  logic [DATA_WIDTH-1:0]           bank_rdata_q [NUM_BANKS];

  // Per-lane decoded address and per-bank arbitration results.
  logic [BANK_W-1:0]               lane_bank [NUM_LANES];
  logic [ROW_W-1:0]                lane_row  [NUM_LANES];
  logic [NUM_LANES-1:0]            grant;
  logic [NUM_BANKS-1:0]            bank_en;
  logic [LANE_W-1:0]               bank_lane  [NUM_BANKS];
  logic [ROW_W-1:0]                bank_row   [NUM_BANKS];
  logic [DATA_WIDTH-1:0]           bank_wdata [NUM_BANKS];

  // Low bits pick the bank, the next bits pick the row; anything above aliases.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_bank[l] = addr_q[l][BANK_W-1:0];
      lane_row[l]  = addr_q[l][BANK_W +: ROW_W];
    end
  end

  // Lanes are scanned in ascending order, so each bank goes to the lowest
  // pending lane that maps to it. Same-address writes therefore retire in
  // lane order and the highest active lane is the one left in memory.
  always_comb begin
    grant   = '0;
    bank_en = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_lane[b]  = '0;
      bank_row[b]   = '0;
      bank_wdata[b] = '0;
    end
    if (state_q == ISSUE) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (pending_q[l] && !bank_en[lane_bank[l]]) begin
          grant[l]                = 1'b1;
          bank_en[lane_bank[l]]    = 1'b1;
          bank_lane[lane_bank[l]]  = LANE_W'(l);
          bank_row[lane_bank[l]]   = lane_row[l];
          bank_wdata[lane_bank[l]] = wdata_q[l*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_en[b]) begin
        if (write_q) begin
          mem[b][bank_row[b]] <= bank_wdata[b];
        end
        bank_rdata_q[b] <= mem[b][bank_row[b]];
      end
    end
  end

  // Next-state logic. Read data registered in a bank lands in its lane slot
  // one cycle later, which is why DRAIN follows the last ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rsp_rdata_d = rsp_rdata_q;
    rd_vld_d    = bank_en & {NUM_BANKS{~write_q}};
    rd_lane_d   = bank_lane;

    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_vld_q[b]) begin
        rsp_rdata_d[int'(rd_lane_q[b])*DATA_WIDTH +: DATA_WIDTH] = bank_rdata_q[b];
      end
    end

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          for (int l = 0; l < NUM_LANES; l++) begin
            addr_d[l] = req_base + ADDR_WIDTH'(l) * req_stride;
          end
          pending_d   = req_mask;
          wdata_d     = req_wdata;
          write_d     = req_write;
          rsp_rdata_d = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        pending_d = pending_q & ~grant;
        if (pending_d == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // Control and lane registers; req_ready is held low while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      pending_q   <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rd_vld_q    <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        addr_q[l] <= '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        rd_lane_q[b] <= '0;
      end
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      write_q     <= write_d;
      pending_q   <= pending_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rd_vld_q    <= rd_vld_d;
      addr_q      <= addr_d;
      rd_lane_q   <= rd_lane_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = write_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef VECTOR_MEMORY_BANKED_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic        first_issue_q, first_issue_d;

  // first_issue marks the one ISSUE cycle per transaction that is not a
  // conflict; every later ISSUE cycle adds one, saturating at all-ones.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    first_issue_d  = first_issue_q;
    if (state_q == IDLE && req_valid && req_ready_q) begin
      first_issue_d = 1'b1;
    end else if (state_q == ISSUE) begin
      first_issue_d = 1'b0;
      if (!first_issue_q && conflict_cnt_q != '1) begin
        conflict_cnt_d = conflict_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt_q <= '0;
      first_issue_q  <= 1'b0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      first_issue_q  <= first_issue_d;
    end
  end

  assign conflict_cycles = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_vector_memory_banked.sv
// ---------------------------------------------------------------------------
// tb_vector_memory_banked
//
// Directed self-checking bench for vector_memory_banked with 4 lanes, 4 banks,
// 16-word banks, 8-bit addresses and 16-bit data. Each scenario task drives
// its own stimulus and compares against hand-computed values. Latency is
// counted in cycles after the acceptance cycle.
// ---------------------------------------------------------------------------
module tb_vector_memory_banked;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NL = 4;
  localparam int NB = 4;
  localparam int BD = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AW-1:0]    req_base;
  logic [AW-1:0]    req_stride;
  logic [NL-1:0]    req_mask;
  logic [DW*NL-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_write;
  logic [DW*NL-1:0] rsp_rdata;
`ifdef VECTOR_MEMORY_BANKED_CONFLICT_CNT_EN
  logic [31:0]      conflict_cycles;
`endif

  int errors = 0;
  int checks = 0;

  vector_memory_banked #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_LANES (NL),
    .NUM_BANKS (NB),
    .BANK_DEPTH(BD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_base       (req_base),
    .req_stride     (req_stride),
    .req_mask       (req_mask),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_write      (rsp_write),
    .rsp_rdata      (rsp_rdata)
`ifdef VECTOR_MEMORY_BANKED_CONFLICT_CNT_EN
    ,
    .conflict_cycles(conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Lane 0 is the least significant element.
  function automatic logic [DW*NL-1:0] pack4(input logic [DW-1:0] d3, input logic [DW-1:0] d2,
                                            input logic [DW-1:0] d1, input logic [DW-1:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  // Counts cycles after acceptance until rsp_valid; -1 if it never arrives.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  // Full transaction: wait for ready, send, wait for the response, accept it.
  task automatic do_txn(input logic wr, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                        input logic [NL-1:0] mask, input logic [DW*NL-1:0] wd,
                        output int lat, output logic [DW*NL-1:0] rd, output logic rw);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_base   = base;
    req_stride = stride;
    req_mask   = mask;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    rd = rsp_rdata;
    rw = rsp_write;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_base   = '0;
    req_stride = '0;
    req_mask   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (rsp_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_write: got %b expected 0", rsp_write); end
    checks++;
    if (rsp_rdata !== '0) begin errors++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
`ifdef VECTOR_MEMORY_BANKED_CONFLICT_CNT_EN
    checks++;
    if (conflict_cycles !== 32'd0) begin errors++; $display("[TB] FAIL reset_conflict: got %0d expected 0", conflict_cycles); end
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_unit_stride;
    int lat;
    logic [DW*NL-1:0] rd;
    logic rw;
    do_txn(1'b1, 8'h10, 8'h01, 4'b1111, pack4(16'h0D, 16'h0C, 16'h0B, 16'h0A), lat, rd, rw);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL unit_wr_lat: got %0d expected 3", lat); end
    checks++;
    if (rw !== 1'b1) begin errors++; $display("[TB] FAIL unit_wr_echo: got %b expected 1", rw); end
    checks++;
    if (rd !== '0) begin errors++; $display("[TB] FAIL unit_wr_rdata: got %h expected 0", rd); end
    do_txn(1'b0, 8'h10, 8'h01, 4'b1111, '0, lat, rd, rw);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL unit_rd_lat: got %0d expected 3", lat); end
    checks++;
    if (rw !== 1'b0) begin errors++; $display("[TB] FAIL unit_rd_echo: got %b expected 0", rw); end
    checks++;
    if (rd !== pack4(16'h0D, 16'h0C, 16'h0B, 16'h0A)) begin
      errors++; $display("[TB] FAIL unit_rd_data: got %h expected %h", rd, pack4(16'h0D, 16'h0C, 16'h0B, 16'h0A));
    end
  endtask

  task automatic test_full_conflict;
    int lat;
    logic [DW*NL-1:0] rd;
    logic rw;
`ifdef VECTOR_MEMORY_BANKED_CONFLICT_CNT_EN
    logic [31:0] before;
    before = conflict_cycles;
`endif
    do_txn(1'b1, 8'h00, 8'h04, 4'b1111, pack4(16'h44, 16'h33, 16'h22, 16'h11), lat, rd, rw);
    checks++;
    if (lat !== 6) begin errors++; $display("[TB] FAIL conflict_wr_lat: got %0d expected 6", lat); end
`ifdef VECTOR_MEMORY_BANKED_CONFLICT_CNT_EN
    checks++;
    if (conflict_cycles - before !== 32'd3) begin
      errors++; $display("[TB] FAIL conflict_count: got +%0d expected +3", conflict_cycles - before);
    end
`endif
    do_txn(1'b0, 8'h00, 8'h04, 4'b1111, '0, lat, rd, rw);
    checks++;
    if (lat !== 6) begin errors++; $display("[TB] FAIL conflict_rd_lat: got %0d expected 6", lat); end
    checks++;
    if (rd !== pack4(16'h44, 16'h33, 16'h22, 16'h11)) begin
      errors++; $display("[TB] FAIL conflict_rd_data: got %h expected %h", rd, pack4(16'h44, 16'h33, 16'h22, 16'h11));
    end
  endtask

  task automatic test_mask_wrap;
    int lat;
    logic [DW*NL-1:0] rd;
    logic rw;
    // Lanes cover 0xFE, 0xFF, 0x00, 0x01 (wrap past the top of the space).
    do_txn(1'b1, 8'hFE, 8'h01, 4'b1111, pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444), lat, rd, rw);
    do_txn(1'b1, 8'hFE, 8'h01, 4'b0101, pack4(16'hAAAA, 16'hCAFE, 16'hBBBB, 16'hBEEF), lat, rd, rw);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL wrap_wr_lat: got %0d expected 3", lat); end
    do_txn(1'b0, 8'hFE, 8'h01, 4'b0101, '0, lat, rd, rw);
    checks++;
    if (rd !== pack4(16'h0, 16'hCAFE, 16'h0, 16'hBEEF)) begin
      errors++; $display("[TB] FAIL wrap_masked_rd: got %h expected %h", rd, pack4(16'h0, 16'hCAFE, 16'h0, 16'hBEEF));
    end
    do_txn(1'b0, 8'hFE, 8'h01, 4'b1111, '0, lat, rd, rw);
    checks++;
    if (rd !== pack4(16'h1111, 16'hCAFE, 16'h3333, 16'hBEEF)) begin
      errors++; $display("[TB] FAIL wrap_full_rd: got %h expected %h", rd, pack4(16'h1111, 16'hCAFE, 16'h3333, 16'hBEEF));
    end
  endtask

  task automatic test_mask_zero;
    int lat;
    logic [DW*NL-1:0] rd;
    logic rw;
    do_txn(1'b0, 8'h10, 8'h01, 4'b0000, '0, lat, rd, rw);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL mask0_lat: got %0d expected 3", lat); end
    checks++;
    if (rd !== '0) begin errors++; $display("[TB] FAIL mask0_rdata: got %h expected 0", rd); end
  endtask

  task automatic test_backpressure;
    int lat;
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_base   = 8'h10;
    req_stride = 8'h01;
    req_mask   = 4'b1111;
    req_wdata  = '0;
    @(posedge clk);
    // Second request stays valid throughout the stalled response.
    #1;
    req_base   = 8'h00;
    req_stride = 8'h04;
    req_mask   = 4'b0001;
    wait_rsp(lat);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL bp_first_lat: got %0d expected 3", lat); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b expected 1", k, rsp_valid); end
      checks++;
      if (rsp_rdata !== pack4(16'h0D, 16'h0C, 16'h0B, 16'h0A)) begin
        errors++; $display("[TB] FAIL bp_hold_rdata[%0d]: got %h expected %h", k, rsp_rdata, pack4(16'h0D, 16'h0C, 16'h0B, 16'h0A));
      end
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_ready[%0d]: got %b expected 0", k, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_drop: got %b expected 0", rsp_valid); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_rise: got %b expected 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL bp_second_lat: got %0d expected 3", lat); end
    checks++;
    if (rsp_rdata !== pack4(16'h0, 16'h0, 16'h0, 16'hCAFE)) begin
      errors++; $display("[TB] FAIL bp_second_data: got %h expected %h", rsp_rdata, pack4(16'h0, 16'h0, 16'h0, 16'hCAFE));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    int lat;
    logic [DW*NL-1:0] rd;
    logic rw;
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_base   = 8'h00;
    req_stride = 8'h04;
    req_mask   = 4'b1111;
    req_wdata  = pack4(16'h4D, 16'h3C, 16'h2B, 16'h1A);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_req_ready: got %b expected 0", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (rsp_write !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rsp_write: got %b expected 0", rsp_write); end
    @(negedge clk);
    reset = 1'b1;
    do_txn(1'b0, 8'h00, 8'h04, 4'b1111, '0, lat, rd, rw);
    checks++;
    if (lat !== 6) begin errors++; $display("[TB] FAIL midrst_rd_lat: got %0d expected 6", lat); end
    checks++;
    if (rd !== pack4(16'h44, 16'h33, 16'h22, 16'h1A)) begin
      errors++; $display("[TB] FAIL midrst_rd_data: got %h expected %h", rd, pack4(16'h44, 16'h33, 16'h22, 16'h1A));
    end
  endtask

  task automatic test_same_address;
    int lat;
    logic [DW*NL-1:0] rd;
    logic rw;
    do_txn(1'b1, 8'h20, 8'h00, 4'b1111, pack4(16'd4, 16'd3, 16'd2, 16'd1), lat, rd, rw);
    checks++;
    if (lat !== 6) begin errors++; $display("[TB] FAIL same_wr_lat: got %0d expected 6", lat); end
    do_txn(1'b0, 8'h20, 8'h00, 4'b1111, '0, lat, rd, rw);
    checks++;
    if (rd !== pack4(16'd4, 16'd4, 16'd4, 16'd4)) begin
      errors++; $display("[TB] FAIL same_rd_data: got %h expected %h", rd, pack4(16'd4, 16'd4, 16'd4, 16'd4));
    end
  endtask

  initial begin
    test_reset();
    test_unit_stride();
    test_full_conflict();
    test_mask_wrap();
    test_mask_zero();
    test_backpressure();
    test_reset_mid_op();
    test_same_address();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vector_memory_banked.md
Name: vector_memory_banked

Overview:
- Parametrised successor to the per-lane vector memory.
- Accepts one vector request per transaction: base address, signed stride and lane mask, for either a gather-read or a scatter-write.
- Maps lane addresses onto NUM_BANKS interleaved single-port banks. Lanes that hit the same bank are serialised over multiple rounds (bank-conflict resolution).
- Returns a single response once every active lane is served. Sits between the SIMD lane datapath and on-chip vector storage.

Parameters:
- DATA_WIDTH, 16, bits per element.
- ADDR_WIDTH, 16, element address width.
- NUM_LANES, 64, vector lanes per request.
- NUM_BANKS, 64, interleaved banks; power of 2, at least 2.
- BANK_DEPTH, 1024, words per bank; power of 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_write  in  1  1 = scatter-write, 0 = gather-read.
- req_base  in  ADDR_WIDTH  address of lane 0.
- req_stride  in  ADDR_WIDTH  two's-complement element stride.
- req_mask  in  NUM_LANES  active-lane mask.
- req_wdata  in  DATA_WIDTH*NUM_LANES  write data, lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_write  out  1  echo of req_write for this transaction.
- rsp_rdata  out  DATA_WIDTH*NUM_LANES  gathered read data.
- conflict_cycles  out  32  present only with the optional feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on port reset.
- Reset values: req_ready=0 while reset is asserted, then 1 in IDLE. rsp_valid=0, rsp_write=0, rsp_rdata=0, all internal pending/lane registers=0. Bank storage is not reset; contents are retained across reset and undefined at power-up.
- Address map:
  - addr_i = req_base + i*req_stride, computed mod 2^ADDR_WIDTH (wraps).
  - bank = addr_i[log2(NUM_BANKS)-1:0].
  - row = addr_i[log2(NUM_BANKS) +: log2(BANK_DEPTH)].
  - Higher address bits are ignored (aliasing).
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch addr_i for all lanes, req_mask into pending, req_wdata, and req_write; go to ISSUE.
  - Clear rsp_rdata lanes to 0 on acceptance.
- ISSUE:
  - req_ready=0.
  - Per bank, grant the lowest-index pending lane mapping to that bank: at most one access per bank per cycle.
  - Writes commit at the clock edge.
  - Reads are registered in the bank and captured into that lane's rsp_rdata slot on the next cycle.
  - Clear pending for granted lanes.
  - If pending after this cycle's grants is zero, go to DRAIN; otherwise stay in ISSUE.
  - An all-zero mask spends exactly one ISSUE cycle with no grants.
- DRAIN: one cycle; the last read data lands. Then go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_write are held stable.
  - On rsp_ready, go to IDLE. In that same cycle rsp_valid falls and req_ready rises the following cycle.
  - No new request is accepted while in RESP.
- Latency: with acceptance in cycle 0 and R conflict rounds (R = max lanes per bank, minimum 1), rsp_valid is first high in cycle R+2.
  - Conflict-free case: cycle 3.
  - Full conflict: NUM_LANES+2.
- Masked-off lanes: never access a bank; their rsp_rdata slot is 0.
- Multiple lanes on the same address:
  - Write: the lanes are serialised in lane order, so the highest active lane's data wins.
  - Read: every lane returns the same value.
- Write responses: rsp_rdata is all zero.
- Reset mid-operation:
  - Asserting reset in ISSUE/DRAIN/RESP returns the FSM to IDLE and drops pending and rsp_valid.
  - Writes committed before reset persist; ungranted lanes are never written.

Optional Feature:
- Macro: VECTOR_MEMORY_BANKED_CONFLICT_CNT_EN.
- Defined:
  - conflict_cycles port exists.
  - Counts ISSUE cycles beyond the first of each transaction, i.e. it adds R-1 per transaction.
  - Saturates at 2^32-1; reset to 0.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan (NUM_LANES=4, NUM_BANKS=4, BANK_DEPTH=16, ADDR_WIDTH=8, DATA_WIDTH=16):
- Unit-stride write: base=0x10, stride=1, mask=4'b1111, wdata={0x0D,0x0C,0x0B,0x0A}. Then a read with the same base/stride/mask.
  - Read returns rdata={0x0D,0x0C,0x0B,0x0A}.
  - Both transactions have rsp_valid in cycle 3 after acceptance.
- Full conflict: stride=4, base=0, mask=4'b1111.
  - All lanes hit bank 0; rsp_valid in cycle 6.
  - conflict_cycles increments by 3 (when the feature is enabled).
- Mask and wrap: read with base=0xFE, stride=0x01, mask=4'b0101.
  - Lane0 reads 0xFE and lane2 reads 0x00 (wrap).
  - Lanes 1 and 3 return 0.
  - mask=0 returns all-zero rsp in cycle 3.
- Backpressure: hold rsp_ready=0 for 5 cycles with a second req_valid pending.
  - rsp_valid and rsp_rdata stay stable; req_ready stays 0.
  - The second request is accepted only after the rsp handshake.
- Reset mid-operation: assert reset in the second ISSUE cycle of a stride-4 write.
  - Outputs take their reset values immediately.
  - A later read shows lane0 written and lanes 1-3 holding their old values.
- Same-address write: stride=0, wdata={4,3,2,1}. A subsequent read of that address returns 4 on all lanes.
